vector_classify_sequencer: RTL and testbench
============================================

Name: vector_classify_sequencer

Overview:
Sequences a vfclass.v instruction over a vector register group through the fixed-latency, non-stallable classify pipeline. For each group member it reads the source register from the VRF, issues it to the classify unit, and captures each returned result in a skid FIFO. Results are written back in order under a valid/ready handshake. The block sits between the vector issue stage and the classify datapath and owns all flow control around it.

Parameters:
VLEN, 128, vector register width in bits
UNIT_LATENCY, 2, cycles from cu_valid to the matching cu_vd
MAX_LMUL, 8, maximum registers in a group
FIFO_DEPTH, 4, result FIFO entries; must be >= UNIT_LATENCY+2

Ports:
clock  in  1  clock
reset  in  1  asynchronous reset, active-high
req_valid  in  1  instruction request valid
req_ready  out  1  sequencer can accept a request
req_vs2  in  5  base source register
req_vd  in  5  base destination register
req_group  in  4  registers in group; 0 is treated as 1; values >MAX_LMUL are clamped to MAX_LMUL
req_vsew  in  2  element width, forwarded to the unit
vrf_rd_en  out  1  VRF read strobe
vrf_rd_addr  out  5  VRF read address
vrf_rd_data  in  VLEN  read data, valid exactly 1 cycle after vrf_rd_en
cu_valid  out  1  operand issued to classify unit
cu_vs2  out  VLEN  operand (vrf_rd_data passed through)
cu_vsew  out  2  latched vsew
cu_vd  in  VLEN  unit result, valid UNIT_LATENCY cycles after cu_valid
wb_valid  out  1  writeback valid (FIFO not empty)
wb_ready  in  1  writeback accepted
wb_addr  out  5  destination register
wb_data  out  VLEN  classify result
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the instruction completes
done_err  out  1  qualifies done; misaligned request

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. FSM = IDLE, counters = 0, FIFO empty, tag pipeline invalid.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: req_ready = 1. When req_valid is high, latch vs2, vd, group (normalised) and vsew, then go to RUN. Not ready in any other state.
- RUN: assert vrf_rd_en with vrf_rd_addr = (vs2 + issued) mod 32 when issued < group and credits > 0. Credit check: outstanding (reads + unit in-flight + FIFO occupancy) < FIFO_DEPTH. Go to DRAIN on the cycle the last read issues.
- Issue path: cu_valid equals vrf_rd_en delayed by 1 cycle; cu_vs2 = vrf_rd_data combinationally.
- Result capture: a tag shift register of length 1+UNIT_LATENCY carries {valid, (vd+idx) mod 32}. When it pops valid, cu_vd and the tag are pushed into the FIFO. The credit scheme guarantees no overflow; a push while full is a design error (assertion).
- Writeback: wb_valid = !empty. The FIFO pops on wb_valid && wb_ready. Push and pop in the same cycle keeps occupancy unchanged. The outstanding counter increments on read issue and decrements on pop; simultaneous increment and decrement leaves it unchanged.
- DRAIN: once written == group (the last pop), pulse done for 1 cycle and return to IDLE. The next request is accepted the cycle after.
- Throughput: 1 register per cycle with wb_ready held high. Request to first wb_valid = 2 + UNIT_LATENCY cycles.
- Reset mid-operation: all state clears immediately. Tag valids clear, so unit results still in flight are dropped and never written back.
- Register indices wrap modulo 32.

Optional Feature:
DRAGONFANG_CLASSIFY_ALIGN_CHECK_EN
- Defined: on acceptance, if group > 1 and (vs2 mod group != 0 or vd mod group != 0, or group is not a power of 2), no reads are issued. FSM goes IDLE -> DRAIN -> IDLE, with done = 1 and done_err = 1 in the cycle after acceptance.
- Undefined: no check is performed, done_err is tied to 0, and misaligned groups wrap modulo 32.

Test Plan:
- group=1, vs2=4, vd=8, vs2 data = +1.0 (fp32 lanes), wb_ready=1 -> one write to addr 8, each lane = 0x040 (bit6). done pulses 1 cycle after the pop, 5 cycles after acceptance.
- group=8, vs2=8, vd=16, wb_ready=1 -> reads 8..15 on consecutive cycles, writes 16..23 in order on consecutive cycles, exactly 1 done.
- group=4, wb_ready=0 for 10 cycles -> vrf_rd_en stops after FIFO_DEPTH=4 reads; no FIFO overflow; all 4 results written in order once wb_ready=1.
- Random wb_ready (50%), group=8 -> written data and addresses match a reference model; outstanding never exceeds 4.
- reset asserted 2 cycles after a group=8 request -> all outputs return to reset values; after release no wb_valid until a new request arrives.
- ALIGN_CHECK_EN, group=4, vs2=6 -> no vrf_rd_en; done = done_err = 1 one cycle after acceptance. Without the macro -> reads 6..9 proceed normally.

Source files
------------

// File: rtl/vector_classify_sequencer.sv
// vector_classify_sequencer: sequences vfclass.v over a register group through the classify pipe; optional DRAGONFANG_CLASSIFY_ALIGN_CHECK_EN rejects misaligned groups
module vector_classify_sequencer #(
  parameter int VLEN = 128,
  parameter int UNIT_LATENCY = 2,
  parameter int MAX_LMUL = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [4:0]      req_vs2_i,
  input  logic [4:0]      req_vd_i,
  input  logic [3:0]      req_group_i,
  input  logic [1:0]      req_vsew_i,
  output logic            vrf_rd_en_o,
  output logic [4:0]      vrf_rd_addr_o,
  input  logic [VLEN-1:0] vrf_rd_data_i,
  output logic            cu_valid_o,
  output logic [VLEN-1:0] cu_vs2_o,
  output logic [1:0]      cu_vsew_o,
  input  logic [VLEN-1:0] cu_vd_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_addr_o,
  output logic [VLEN-1:0] wb_data_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            done_err_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [4:0] vs2_q, vd_q;
  logic [3:0] group_q, issued_q, written_q, grp_n;
  logic [1:0] vsew_q;
  logic [CW-1:0] out_q, cnt_q;
  logic [PW-1:0] wp_q, rp_q;
  logic tag_v_q [UNIT_LATENCY+1];
  logic [4:0] tag_a_q [UNIT_LATENCY+1];
  logic [VLEN-1:0] mem_d_q [FIFO_DEPTH];
  logic [4:0] mem_a_q [FIFO_DEPTH];
  logic accept, rd_en, push, pop, empty, full, mis, err_q;

  assign grp_n = (req_group_i == 4'd0) ? 4'd1 :
                 (req_group_i > 4'(MAX_LMUL)) ? 4'(MAX_LMUL) : req_group_i;
  assign accept = (state_q == IDLE) && req_valid_i;
  assign empty = (cnt_q == '0);
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign pop = !empty && wb_ready_i;
  assign push = tag_v_q[UNIT_LATENCY];
  // a pop this cycle frees a credit, which keeps one register per cycle at full writeback rate
  assign rd_en = (state_q == RUN) && (issued_q < group_q) && ((out_q < CW'(FIFO_DEPTH)) || pop);

`ifdef DRAGONFANG_CLASSIFY_ALIGN_CHECK_EN
  assign mis = (grp_n > 4'd1) && (((req_vs2_i[3:0] & (grp_n - 4'd1)) != 4'd0) ||
               ((req_vd_i[3:0] & (grp_n - 4'd1)) != 4'd0) || ((grp_n & (grp_n - 4'd1)) != 4'd0));
  // remember whether the accepted request was rejected as misaligned
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) err_q <= 1'b0;
    else if (accept) err_q <= mis;
  assign done_err_o = done_o & err_q;
`else
  assign mis = 1'b0;
  assign err_q = 1'b0;
  assign done_err_o = 1'b0;
`endif

  assign req_ready_o = (state_q == IDLE);
  assign busy_o = (state_q != IDLE);
  assign vrf_rd_en_o = rd_en;
  assign vrf_rd_addr_o = vs2_q + {1'b0, issued_q};
  assign cu_valid_o = tag_v_q[0];
  assign cu_vs2_o = vrf_rd_data_i;
  assign cu_vsew_o = vsew_q;
  assign wb_valid_o = !empty;
  assign wb_data_o = mem_d_q[rp_q];
  assign wb_addr_o = mem_a_q[rp_q];

  // next state and completion pulse
  always_comb begin
    state_d = state_q;
    done_o = 1'b0;
    case (state_q)
      IDLE: state_d = accept ? (mis ? DRAIN : RUN) : IDLE;
      RUN: state_d = (rd_en && (issued_q + 4'd1 == group_q)) ? DRAIN : RUN;
      DRAIN: begin
        done_o = err_q || (written_q == group_q);
        state_d = done_o ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, latched request fields and progress counters
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      vs2_q <= '0;
      vd_q <= '0;
      group_q <= '0;
      vsew_q <= '0;
      issued_q <= '0;
      written_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vs2_q <= req_vs2_i;
        vd_q <= req_vd_i;
        group_q <= grp_n;
        vsew_q <= req_vsew_i;
      end
      issued_q <= accept ? 4'd0 : issued_q + {3'b0, rd_en};
      written_q <= accept ? 4'd0 : written_q + {3'b0, pop};
      out_q <= out_q + CW'(rd_en) - CW'(pop);
    end

  // destination tags travel alongside the operand through the fixed-latency unit
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      for (int i = 0; i <= UNIT_LATENCY; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_a_q[i] <= '0;
      end
    end else begin
      tag_v_q[0] <= rd_en;
      tag_a_q[0] <= vd_q + {1'b0, issued_q};
      for (int i = 1; i <= UNIT_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_a_q[i] <= tag_a_q[i-1];
      end
    end

  // result FIFO absorbing unit returns while writeback is back-pressured
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d_q[i] <= '0;
        mem_a_q[i] <= '0;
      end
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_d_q[wp_q] <= cu_vd_i;
        mem_a_q[wp_q] <= tag_a_q[UNIT_LATENCY];
        wp_q <= (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + 1'b1;
      end
      if (pop) rp_q <= (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end

  no_overflow: assert property (@(posedge clock_i) disable iff (reset_i) !(push && full));
endmodule

// File: tb/tb_vector_classify_sequencer.sv
// tb_vector_classify_sequencer: table-driven and randomized checks against a queue-based reference model
module tb_vector_classify_sequencer;
  localparam int VLEN = 128;
  localparam int UL = 2;
`ifdef DRAGONFANG_CLASSIFY_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [4:0] req_vs2 = '0, req_vd = '0;
  logic [3:0] req_group = '0;
  logic [1:0] req_vsew = '0;
  logic vrf_rd_en;
  logic [4:0] vrf_rd_addr;
  logic [VLEN-1:0] vrf_rd_data;
  logic cu_valid;
  logic [VLEN-1:0] cu_vs2, cu_vd;
  logic [1:0] cu_vsew;
  logic wb_valid, wb_ready = 1'b1;
  logic [4:0] wb_addr;
  logic [VLEN-1:0] wb_data;
  logic busy, done, done_err;

  vector_classify_sequencer dut (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_vs2_i(req_vs2), .req_vd_i(req_vd), .req_group_i(req_group), .req_vsew_i(req_vsew),
    .vrf_rd_en_o(vrf_rd_en), .vrf_rd_addr_o(vrf_rd_addr), .vrf_rd_data_i(vrf_rd_data),
    .cu_valid_o(cu_valid), .cu_vs2_o(cu_vs2), .cu_vsew_o(cu_vsew), .cu_vd_i(cu_vd),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .busy_o(busy), .done_o(done), .done_err_o(done_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] a; logic [VLEN-1:0] d;} wb_t;
  typedef struct {logic [4:0] vs2; logic [4:0] vd; logic [3:0] grp; int mode; int lat;} vec_t;

  logic [VLEN-1:0] vrf [32];
  logic [VLEN-1:0] up [UL];
  wb_t exp_wb [$];
  logic [4:0] exp_rd [$];
  wb_t mon_e;
  int tests = 0, fails = 0;
  int rd_total = 0, outst = 0, max_out = 0;
  logic [VLEN-1:0] last_data = '0;
  logic [4:0] last_addr = '0;
  vec_t tbl [8];

  function automatic logic [31:0] fcl(input logic [31:0] x);
    int b;
    if (x[30:23] == 8'hff) b = (x[22:0] == 0) ? (x[31] ? 0 : 7) : (x[22] ? 9 : 8);
    else if (x[30:23] == 8'h00) b = (x[22:0] == 0) ? (x[31] ? 3 : 4) : (x[31] ? 2 : 5);
    else b = x[31] ? 1 : 6;
    return 32'd1 << b;
  endfunction

  function automatic logic [VLEN-1:0] fcl_v(input logic [VLEN-1:0] v);
    logic [VLEN-1:0] r;
    for (int l = 0; l < VLEN / 32; l++) r[32*l +: 32] = fcl(v[32*l +: 32]);
    return r;
  endfunction

  function automatic logic [31:0] pick(input int k);
    case (k)
      0: return 32'h3f800000;
      1: return 32'hc0200000;
      2: return 32'h00000000;
      3: return 32'h80000000;
      4: return 32'h7f800000;
      5: return 32'hff800000;
      6: return 32'h7fc00000;
      7: return 32'h7f800001;
      8: return 32'h00000001;
      9: return 32'h80000010;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic align_err(input int vs2, input int vd, input int g);
    return ALIGN_EN && g > 1 && (vs2 % g != 0 || vd % g != 0 || !(g inside {1, 2, 4, 8}));
  endfunction

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // VRF with one-cycle read latency
  always @(posedge clk or posedge rst)
    if (rst) vrf_rd_data <= '0;
    else if (vrf_rd_en) vrf_rd_data <= vrf[vrf_rd_addr];

  // classify unit: pure function with UL cycles of latency, never stalls
  always @(posedge clk) begin
    up[0] <= fcl_v(cu_vs2);
    for (int i = 1; i < UL; i++) up[i] <= up[i-1];
  end
  assign cu_vd = up[UL-1];

  // read-address and writeback scoreboard, plus outstanding tracking
  always @(negedge clk) begin
    if (rst) outst = 0;
    else begin
      if (vrf_rd_en) begin
        rd_total++;
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got read of %0d, expected no read", vrf_rd_addr);
        end else chk("rd_addr", VLEN'(vrf_rd_addr), VLEN'(exp_rd.pop_front()));
      end
      if (wb_valid && wb_ready) begin
        last_data = wb_data;
        last_addr = wb_addr;
        if (exp_wb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got write to %0d, expected no write", wb_addr);
        end else begin
          mon_e = exp_wb.pop_front();
          chk("wb_addr", VLEN'(wb_addr), VLEN'(mon_e.a));
          chk("wb_data", wb_data, mon_e.d);
        end
      end
      outst = outst + int'(vrf_rd_en) - int'(wb_valid && wb_ready);
      if (outst > max_out) max_out = outst;
    end
  end

  task automatic check_rst();
    chk("rst_req_ready", VLEN'(req_ready), 1);
    chk("rst_busy", VLEN'(busy), 0);
    chk("rst_done", VLEN'({done, done_err}), 0);
    chk("rst_rd_en", VLEN'({vrf_rd_en, vrf_rd_addr}), 0);
    chk("rst_cu", VLEN'({cu_valid, cu_vsew}), 0);
    chk("rst_cu_vs2", cu_vs2, 0);
    chk("rst_wb", VLEN'({wb_valid, wb_addr}), 0);
    chk("rst_wb_data", wb_data, 0);
  endtask

  // mode 0: wb_ready held high; 1: random 50%; 2: low for 10 cycles then high
  task automatic run(input logic [4:0] vs2, input logic [4:0] vd, input logic [3:0] grp,
                     input int mode, input int lat_in);
    int g, lat, got, rd0;
    logic err;
    g = (grp == 0) ? 1 : (grp > 8) ? 8 : int'(grp);
    err = align_err(int'(vs2), int'(vd), g);
    lat = err ? 0 : lat_in;
    if (!err)
      for (int i = 0; i < g; i++) begin
        exp_rd.push_back(5'(vs2 + i));
        exp_wb.push_back('{a: 5'(vd + i), d: fcl_v(vrf[5'(vs2 + i)])});
      end
    got = 0;
    while (!req_ready && got < 50) begin
      @(posedge clk);
      #1;
      got++;
    end
    chk("req_ready", VLEN'(req_ready), 1);
    req_vs2 = vs2;
    req_vd = vd;
    req_group = grp;
    req_vsew = 2'd2;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("busy", VLEN'(busy), 1);
    chk("cu_vsew", VLEN'(cu_vsew), 2);
    rd0 = rd_total;
    got = -1;
    for (int c = 0; c < 300; c++) begin
      if (mode == 2 && c == 10) chk("stall_reads", VLEN'(rd_total - rd0), VLEN'((g < 4) ? g : 4));
      if (done) begin
        got = c;
        break;
      end
      wb_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : (c >= 10);
      @(posedge clk);
      #1;
    end
    if (lat >= 0) chk("done_lat", VLEN'(got), VLEN'(lat));
    else chk("done_seen", VLEN'(got >= 0), 1);
    chk("done_err", VLEN'(done_err), VLEN'(err));
    chk("wb_left", VLEN'(exp_wb.size()), 0);
    chk("rd_left", VLEN'(exp_rd.size()), 0);
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("done_pulse", VLEN'(done), 0);
    chk("idle", VLEN'(req_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, g;
    tbl[0] = '{vs2: 5'd4,  vd: 5'd8,  grp: 4'd1,  mode: 0, lat: 5};
    tbl[1] = '{vs2: 5'd8,  vd: 5'd16, grp: 4'd8,  mode: 0, lat: 12};
    tbl[2] = '{vs2: 5'd0,  vd: 5'd4,  grp: 4'd4,  mode: 2, lat: -1};
    tbl[3] = '{vs2: 5'd10, vd: 5'd3,  grp: 4'd0,  mode: 0, lat: 5};
    tbl[4] = '{vs2: 5'd16, vd: 5'd24, grp: 4'd15, mode: 0, lat: 12};
    tbl[5] = '{vs2: 5'd6,  vd: 5'd12, grp: 4'd4,  mode: 0, lat: 8};
    tbl[6] = '{vs2: 5'd30, vd: 5'd0,  grp: 4'd2,  mode: 0, lat: 6};
    tbl[7] = '{vs2: 5'd0,  vd: 5'd8,  grp: 4'd8,  mode: 1, lat: -1};
    for (int r = 0; r < 32; r++)
      for (int l = 0; l < VLEN / 32; l++) vrf[r][32*l +: 32] = pick($urandom_range(0, 10));
    vrf[4] = {4{32'h3f800000}};
    repeat (3) @(posedge clk);
    #1;
    check_rst();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].vs2, tbl[i].vd, tbl[i].grp, tbl[i].mode, tbl[i].lat);
      if (i == 0) begin
        chk("t1_addr", VLEN'(last_addr), 8);
        chk("t1_data", last_data, {4{32'h00000040}});
      end
    end
    for (int i = 0; i < 8; i++) exp_rd.push_back(5'(8 + i));
    for (int i = 0; i < 8; i++) exp_wb.push_back('{a: 5'(16 + i), d: fcl_v(vrf[8 + i])});
    req_vs2 = 5'd8;
    req_vd = 5'd16;
    req_group = 4'd8;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check_rst();
    exp_rd.delete();
    exp_wb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (wb_valid || vrf_rd_en || cu_valid || busy) seen++;
    end
    chk("post_rst_quiet", VLEN'(seen), 0);
    run(5'd8, 5'd16, 4'd8, 0, 12);
    for (int i = 0; i < 20; i++) begin
      g = $urandom_range(0, 15);
      if (i % 2 == 0) run(5'($urandom), 5'($urandom), 4'(g), 1, -1);
      else run(5'($urandom), 5'($urandom), 4'(g), 0, 4 + ((g == 0) ? 1 : (g > 8) ? 8 : g));
    end
    chk("max_outstanding_le4", VLEN'(max_out <= 4), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
